// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate data-cache controller with 4-word blocks.
// Define DCACHE_STATS_EN to add saturating hit_cnt/miss_cnt outputs.
module dcache_ctrl #(
  parameter int ADDR_W  = 12,
  parameter int INDEX_W = 5,
  parameter int DATA_W  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              stall,
  output logic              mm_rd_req,
  output logic              mm_wr_req,
  output logic [ADDR_W-1:0] mm_addr,
  output logic [DATA_W-1:0] mm_wdata,
  input  logic [DATA_W-1:0] mm_rdata,
  input  logic              mm_rvalid,
  input  logic              mm_wack
`ifdef DCACHE_STATS_EN
  ,
  output logic [15:0]       hit_cnt,
  output logic [15:0]       miss_cnt
`endif
);
  localparam int LINES = 1 << INDEX_W;
  localparam int TAG_W = ADDR_W - 4 - INDEX_W;

  typedef enum logic [1:0] {S_IDLE, S_REFILL, S_WRITE} state_t;

  state_t            r_state;
  logic [1:0]        r_cnt;
  logic [LINES-1:0]  r_valid;
  logic [TAG_W-1:0]  r_tag_arr  [LINES];
  logic [DATA_W-1:0] r_data_arr [LINES][4];

  logic [TAG_W-1:0]   w_tag;
  logic [INDEX_W-1:0] w_index;
  logic [1:0]         w_offset;
  logic               w_hit;
  logic               w_is_wr;
  logic               w_is_rd;
  logic               w_last_beat;
  logic               w_unused_lsb;

  assign w_offset     = addr[3:2];
  assign w_index      = addr[3+INDEX_W:4];
  assign w_tag        = addr[ADDR_W-1:4+INDEX_W];
  assign w_unused_lsb = ^addr[1:0];
  assign w_hit        = r_valid[w_index] & (r_tag_arr[w_index] == w_tag);
  // A simultaneous read+write request is serviced as a store.
  assign w_is_wr      = mem_write;
  assign w_is_rd      = mem_read & ~mem_write;
  assign w_last_beat  = (r_state == S_REFILL) & mm_rvalid & (r_cnt == 2'd3);

  always_comb begin
    stall     = 1'b0;
    rdata     = '0;
    mm_rd_req = 1'b0;
    mm_wr_req = 1'b0;
    mm_addr   = '0;
    mm_wdata  = '0;
    case (r_state)
      S_IDLE: begin
        if (w_is_wr) begin
          stall = 1'b1;
        end else if (w_is_rd) begin
          if (w_hit) rdata = r_data_arr[w_index][w_offset];
          else       stall = 1'b1;
        end
      end
      S_REFILL: begin
        stall     = 1'b1;
        mm_rd_req = 1'b1;
        mm_addr   = {w_tag, w_index, 4'b0000};
      end
      S_WRITE: begin
        stall     = ~mm_wack;
        mm_wr_req = 1'b1;
        mm_addr   = addr;
        mm_wdata  = wdata;
      end
      default: ;
    endcase
    // The core may still present a missing load while reset is held; keep it running freely.
    if (!rst_n) stall = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= 2'd0;
      r_valid <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_is_wr) begin
            r_state <= S_WRITE;
          end else if (w_is_rd && !w_hit) begin
            r_state <= S_REFILL;
            r_cnt   <= 2'd0;
          end
        end
        S_REFILL: begin
          if (mm_rvalid) r_cnt <= r_cnt + 2'd1;
          if (w_last_beat) begin
            r_valid[w_index] <= 1'b1;
            r_state          <= S_IDLE;
          end
        end
        S_WRITE: begin
          if (mm_wack) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Tag and data storage carry no reset; the valid bits alone qualify their contents.
  always_ff @(posedge clk) begin
    if (r_state == S_REFILL && mm_rvalid) begin
      r_data_arr[w_index][r_cnt] <= mm_rdata;
      if (r_cnt == 2'd3) r_tag_arr[w_index] <= w_tag;
    end else if (r_state == S_WRITE && mm_wack && w_hit) begin
      r_data_arr[w_index][w_offset] <= wdata;
    end
  end

`ifdef DCACHE_STATS_EN
  logic        r_after_refill;
  logic [15:0] r_hit_cnt;
  logic [15:0] r_miss_cnt;

  // The hit that ends a refill belongs to an access already counted as a miss.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_after_refill <= 1'b0;
      r_hit_cnt      <= 16'd0;
      r_miss_cnt     <= 16'd0;
    end else begin
      r_after_refill <= w_last_beat;
      if (r_state == S_IDLE && w_is_rd && w_hit && !r_after_refill && r_hit_cnt != 16'hFFFF)
        r_hit_cnt <= r_hit_cnt + 16'd1;
      if (r_state == S_IDLE && w_is_rd && !w_hit && r_miss_cnt != 16'hFFFF)
        r_miss_cnt <= r_miss_cnt + 16'd1;
    end
  end

  assign hit_cnt  = r_hit_cnt;
  assign miss_cnt = r_miss_cnt;
`endif
endmodule
